pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_skid_reg.sv | 103 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register: occupancy state
// encoding and default payload / stall-counter widths.
package pipe_pkg;

  localparam int DEFAULT_DATA_W = 96;
  localparam int DEFAULT_CNT_W  = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised saturating incrementer. Counts up by one on each
// cycle with inc high, sticks at all-ones, and is cleared only by reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         cpu_clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Increment when requested unless already saturated.
  always_ff @(posedge cpu_clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + ONE;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register between fetch-side pipeline stages.
// out_valid and in_ready are decoded from registered state only, so there is
// no combinational path from in_valid or out_ready to the handshake outputs.
// Optional feature: define PIPE_STALL_CNT_EN to add the saturating stall_cnt
// output (counts cycles with out_valid high and out_ready low).
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // State and storage registers; reset outranks the flush handled below.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and storage update: main always holds the oldest entry,
  // skid only catches a word that arrives while main is stalled.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          case ({in_fire, out_fire})
            2'b11: main_d = in_data;
            2'b10: begin
              skid_d  = in_data;
              state_d = FULL;
            end
            2'b01: state_d = EMPTY;
            default: state_d = BUSY;
          endcase
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .cpu_clk(cpu_clk),
    .reset  (reset),
    .inc    (out_valid & ~out_ready),
    .count  (stall_cnt)
  );
`endif

endmodule
